// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clkdiv_pkg
// Brief   : Shared constants and sizing helpers for the even clock divider.
// Revision: 1.0
// ============================================================================
package clkdiv_pkg;

  localparam int DEFAULT_DIVISOR = 28;
  localparam int MIN_DIVISOR     = 2;
  localparam int MAX_DIVISOR     = 65536;

  // A one-state counter still needs a one-bit register to exist.
  function automatic int clkdiv_cnt_width(input int half);
    int w;
    w = $clog2(half);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit clkdiv_divisor_ok(input int divisor);
    return (divisor >= MIN_DIVISOR) && (divisor <= MAX_DIVISOR) && ((divisor % 2) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module  : mod_n_counter
// Brief   : Free-running 0..N-1 counter with a combinational terminal count.
// Revision: 1.0
// ============================================================================
module mod_n_counter
  import clkdiv_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_tc
);

  localparam int CNT_W = clkdiv_cnt_width(N);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

  logic [CNT_W-1:0] r_count;

  assign o_tc = (r_count == c_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (o_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/even_clock_divider.sv
`default_nettype none
// ============================================================================
// Module  : even_clock_divider
// Brief   : 50% duty even-ratio divider with a one-cycle rising-edge strobe.
// Revision: 1.0
// ============================================================================
module even_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clk,
  input  logic rst,
  output logic divBy28,
  output logic tick
);

  localparam int HALF = DIVISOR / 2;

  if (!clkdiv_divisor_ok(DIVISOR)) begin : g_bad_divisor
    $error("even_clock_divider: DIVISOR must be even and within 2..65536");
  end

  logic w_tc;
  logic r_q;
  logic r_tick;

  mod_n_counter #(
    .N (HALF)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .o_tc (w_tc)
  );

  // The strobe fires on the same edge that moves q from 0 to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_tc) begin
        r_q    <= ~r_q;
        r_tick <= ~r_q;
      end
    end
  end

  assign divBy28 = r_q;
  assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_even_clock_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_even_clock_divider
// Brief   : Directed vector-table bench for even_clock_divider.
// Revision: 1.0
// ============================================================================
module tb_even_clock_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q28, t28, q2, t2, q4, t4, q6, t6;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  even_clock_divider #(.DIVISOR(28)) dut   (.clk(clk), .rst(rst), .divBy28(q28), .tick(t28));
  even_clock_divider #(.DIVISOR(2))  dut2  (.clk(clk), .rst(rst), .divBy28(q2),  .tick(t2));
  even_clock_divider #(.DIVISOR(4))  dut4  (.clk(clk), .rst(rst), .divBy28(q4),  .tick(t4));
  even_clock_divider #(.DIVISOR(6))  dut6  (.clk(clk), .rst(rst), .divBy28(q6),  .tick(t6));

  typedef struct {
    logic rst_v;
    int   n_edges;
    logic exp_q;
    logic exp_tick;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst_v, input int n);
    rst = rst_v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int cur_cnt();
    return int'(dut.u_counter.r_count);
  endfunction

  function automatic int model_q(input int k, input int half);
    return (k / half) % 2;
  endfunction

  function automatic int model_tick(input int k, input int half);
    return ((k % (2 * half)) == half) ? 1 : 0;
  endfunction

  initial begin
    time rise_t[$];
    time fall_t[$];
    int  prev_q;
    int  ticks;

    vecs[0]  = '{1'b1, 4,  1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 13, 1'b0, 1'b0, 13};
    vecs[2]  = '{1'b0, 1,  1'b1, 1'b1, 0};
    vecs[3]  = '{1'b0, 1,  1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 12, 1'b1, 1'b0, 13};
    vecs[5]  = '{1'b0, 1,  1'b0, 1'b0, 0};
    vecs[6]  = '{1'b0, 14, 1'b1, 1'b1, 0};
    vecs[7]  = '{1'b0, 3,  1'b1, 1'b0, 3};
    vecs[8]  = '{1'b1, 1,  1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 3,  1'b0, 1'b0, 3};
    vecs[10] = '{1'b1, 1,  1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 13, 1'b0, 1'b0, 13};
    vecs[12] = '{1'b0, 1,  1'b1, 1'b1, 0};
    vecs[13] = '{1'b1, 1,  1'b0, 1'b0, 0};
    vecs[14] = '{1'b0, 20, 1'b1, 1'b0, 6};
    vecs[15] = '{1'b1, 1,  1'b0, 1'b0, 0};
    vecs[16] = '{1'b0, 14, 1'b1, 1'b1, 0};

    // Power-up reset held for 4 edges, outputs checked on every edge.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1);
      chk($sformatf("por_q[%0d]", i),    int'(q28), 0);
      chk($sformatf("por_tick[%0d]", i), int'(t28), 0);
      chk($sformatf("por_cnt[%0d]", i),  cur_cnt(), 0);
      chk($sformatf("por_q2[%0d]", i),   int'(q2),  0);
    end

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst_v, vecs[i].n_edges);
      chk($sformatf("vec%0d_q", i),    int'(q28),  int'(vecs[i].exp_q));
      chk($sformatf("vec%0d_tick", i), int'(t28),  int'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_cnt", i),  cur_cnt(),  vecs[i].exp_cnt);
    end

    // Free run over three full periods, every divider checked on every edge.
    apply(1'b1, 1);
    rst    = 1'b0;
    prev_q = 0;
    ticks  = 0;
    for (int k = 1; k <= 84; k++) begin
      apply(1'b0, 1);
      chk($sformatf("run28_q@%0d", k),    int'(q28), model_q(k, 14));
      chk($sformatf("run28_tick@%0d", k), int'(t28), model_tick(k, 14));
      chk($sformatf("run2_q@%0d", k),     int'(q2),  model_q(k, 1));
      chk($sformatf("run2_tick@%0d", k),  int'(t2),  model_tick(k, 1));
      chk($sformatf("run4_q@%0d", k),     int'(q4),  model_q(k, 2));
      chk($sformatf("run4_tick@%0d", k),  int'(t4),  model_tick(k, 2));
      chk($sformatf("run6_q@%0d", k),     int'(q6),  model_q(k, 3));
      chk($sformatf("run6_tick@%0d", k),  int'(t6),  model_tick(k, 3));
      if (t28) ticks++;
      if (prev_q == 0 && q28) rise_t.push_back($time);
      if (prev_q == 1 && !q28) fall_t.push_back($time);
      prev_q = int'(q28);
    end

    chk("rise_count", rise_t.size(), 3);
    chk("fall_count", fall_t.size(), 3);
    chk("tick_count", ticks, 3);
    if (rise_t.size() == 3 && fall_t.size() == 3) begin
      chk("high_ns",    int'(fall_t[0] - rise_t[0]), 280);
      chk("low_ns",     int'(rise_t[1] - fall_t[0]), 280);
      chk("period1_ns", int'(rise_t[1] - rise_t[0]), 560);
      chk("period2_ns", int'(rise_t[2] - rise_t[1]), 560);
      chk("high3_ns",   int'(fall_t[2] - rise_t[2]), 280);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
